reg_scoreboard: RTL

// - Register-hazard controller between the decode and data-fetch stages. Generalises the single-bit

---
 rtl/core_pkg.sv | 13 +
 rtl/sb_counter.sv | 25 ++
 rtl/reg_scoreboard.sv | 101 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and sizing for the register scoreboard.
// Optional macro: SCOREBOARD_BYPASS_EN (writeback forwarding on hazard check).
package core_pkg;
  localparam int NREGS   = 32;
  localparam int RIDX_W  = 5;
  localparam int CNT_W   = 2;
  localparam int STALL_W = 16;

  typedef logic [CNT_W-1:0]  sb_cnt_t;
  typedef logic [RIDX_W-1:0] reg_idx_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;
endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight writer counter.
// Simultaneous inc and dec hold the value; clr dominates.
module sb_counter
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && !dec)
      cnt <= cnt + 1'b1;
    else if (dec && !inc)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-to-fetch register hazard scoreboard with writer counts.
// Optional macro: SCOREBOARD_BYPASS_EN (last writer's writeback clears hazard).
module reg_scoreboard
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [2:0]         iss_src_vld,
  input  logic [RIDX_W-1:0]  iss_src0,
  input  logic [RIDX_W-1:0]  iss_src1,
  input  logic [RIDX_W-1:0]  iss_src2,
  input  logic               iss_dst_vld,
  input  logic [RIDX_W-1:0]  iss_dst,
  input  logic               wb_valid,
  input  logic [RIDX_W-1:0]  wb_dst,
  input  logic               flush,
  output logic [NREGS-1:0]   busy_vec,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               sb_err
);

  sb_cnt_t          cnt [NREGS];
  logic [NREGS-1:0] zero;
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;
  reg_idx_t         src [3];
  logic             hazard;
  logic             full;
  logic             accept;
  logic             clr;
  logic             stray;

  assign src[0] = iss_src0;
  assign src[1] = iss_src1;
  assign src[2] = iss_src2;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (iss_src_vld[i] && !zero[src[i]]) begin
`ifdef SCOREBOARD_BYPASS_EN
        if (!(cnt[src[i]] == sb_cnt_t'(1) &&
              wb_valid && wb_dst == src[i]))
          hazard = 1'b1;
`else
        hazard = 1'b1;
`endif
      end
    end
  end

  assign full = iss_dst_vld &&
                (cnt[iss_dst] == SB_CNT_MAX);
  assign iss_ready = reset_n && !flush &&
                     !hazard && !full;
  assign accept = iss_valid && iss_ready;
  assign clr = !reset_n || flush;

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : g_cnt
      assign inc[g] = accept && iss_dst_vld &&
                      (iss_dst == RIDX_W'(g));
      // a writeback may consume a same-cycle increment
      assign dec[g] = reset_n && !flush && wb_valid &&
                      (wb_dst == RIDX_W'(g)) &&
                      (!zero[g] || inc[g]);
      sb_counter u_cnt (
        .clk  (clk),
        .clr  (clr),
        .inc  (inc[g]),
        .dec  (dec[g]),
        .cnt  (cnt[g]),
        .zero (zero[g])
      );
    end
  endgenerate

  assign busy_vec = ~zero;

  assign stray = reset_n && !flush && wb_valid &&
                 zero[wb_dst] && !inc[wb_dst];

  always_ff @(posedge clk) begin
    if (!reset_n)
      sb_err <= 1'b0;
    else if (stray)
      sb_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (iss_valid && !iss_ready && !flush &&
             stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
